// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
//   Shared definitions for the clock-setting button front end:
//   FSM state encoding, step direction encoding, and default timing
//   constants for a 100 MHz system clock.
//   Optional feature macro used by the design: UPDOWN_STEP_CTRL_AUTOREPEAT_EN
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // 100 MHz: 0.5 ms debounce, 100 ms to first repeat, 25 ms repeat period
    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd10000000;
    localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd2500000;

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   2-flop synchroniser followed by a level debouncer. The accepted level
//   flips only after the synchronised input has disagreed with it for
//   DEBOUNCE_CYCLES consecutive cycles.
//   Ports:
//     i_clk      system clock
//     i_reset_n  asynchronous active-low reset
//     i_raw      raw button input, asynchronous to i_clk
//     o_level    debounced (accepted) level
module button_debounce
    import step_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter runs only while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/updown_step_ctrl.sv
// updown_step_ctrl
//   Turns two raw clock-setting push-buttons into single-cycle up/down step
//   commands for the minute/second counters: one step per press, optional
//   timed auto-repeat while held, and a lockout while both are pressed.
//   Auto-repeat is built only when UPDOWN_STEP_CTRL_AUTOREPEAT_EN is defined;
//   otherwise each press yields exactly one step.
//   Ports:
//     i_clk       system clock
//     i_reset_n   asynchronous active-low reset
//     i_btn_up    raw up button (active-high, asynchronous)
//     i_btn_down  raw down button (active-high, asynchronous)
//     o_ena       one-cycle step strobe (o_up | o_down)
//     o_up        one-cycle count-up command
//     o_down      one-cycle count-down command
module updown_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn_up,
    input  logic i_btn_down,
    output logic o_ena,
    output logic o_up,
    output logic o_down
);

    logic   lvl_up, lvl_dn;
    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    logic   up_q, up_d, down_q, down_d, ena_q, ena_d;
    logic   step;
    logic   held, other;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_raw    (i_btn_up),
        .o_level  (lvl_up)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_raw    (i_btn_down),
        .o_level  (lvl_dn)
    );

    assign held  = (dir_q == DIR_DOWN) ? lvl_dn : lvl_up;
    assign other = (dir_q == DIR_DOWN) ? lvl_up : lvl_dn;

`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
    logic [23:0] timer_q, timer_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        step    = 1'b0;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (lvl_up && lvl_dn) begin
                    state_d = LOCK;
                end else if (lvl_up || lvl_dn) begin
                    dir_d   = lvl_dn ? DIR_DOWN : DIR_UP;
                    step    = 1'b1;
                    state_d = HOLD;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
                    timer_d = REPEAT_DELAY - 24'd1;
`endif
                end
            end
            HOLD, REPEAT: begin
                // release beats lock, lock beats timer expiry
                if (!held) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = LOCK;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
                end else if (timer_q == 24'd0) begin
                    step    = 1'b1;
                    timer_d = REPEAT_PERIOD - 24'd1;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q - 24'd1;
`endif
                end
            end
            LOCK: begin
                // wait for full release so a partial release never steps
                if (!lvl_up && !lvl_dn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        up_d   = step && (dir_d == DIR_UP);
        down_d = step && (dir_d == DIR_DOWN);
        ena_d  = step;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            ena_q   <= 1'b0;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
            timer_q <= 24'd0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            up_q    <= up_d;
            down_q  <= down_d;
            ena_q   <= ena_d;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign o_up   = up_q;
    assign o_down = down_q;
    assign o_ena  = ena_q;

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Bench for updown_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=5. Expected step edges are pushed to a queue when a button
// is driven and popped as the DUT emits steps.
module tb_updown_step_ctrl;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = 2 + DB;
`ifdef UPDOWN_STEP_CTRL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic o_ena, o_up, o_down;

    updown_step_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd5)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_btn_up  (btn_up),
        .i_btn_down(btn_dn),
        .o_ena     (o_ena),
        .o_up      (o_up),
        .o_down    (o_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int edge_no;
        bit down;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;
    int n_up = 0;
    int n_dn = 0;

    // Scoreboard side: every step the DUT emits must match the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (o_ena !== (o_up | o_down) || (o_up && o_down)) begin
            failures++;
            $display("FAIL ena_consistency cyc=%0d got ena=%b up=%b down=%b", cyc, o_ena, o_up, o_down);
        end
        if (o_up || o_down) begin
            if (o_up) n_up++;
            if (o_down) n_dn++;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step at edge %0d up=%b down=%b, expected none", cyc, o_up, o_down);
            end else begin
                e = sbq.pop_front();
                if (e.edge_no != cyc || e.down != o_down) begin
                    failures++;
                    $display("FAIL step_timing got edge %0d down=%b, expected edge %0d down=%b",
                             cyc, o_down, e.edge_no, e.down);
                end
            end
        end
    end

    // Button first sampled at edge n and first sampled released at n+hold.
    task automatic push_steps(input bit down, input int n, input int hold);
        int  e;
        bit  first;
        exp_t x;
        if (hold < DB) return;
        e = n + LAT;
        first = 1'b1;
        while (e < n + hold + LAT) begin
            x.edge_no = e;
            x.down = down;
            sbq.push_back(x);
            if (!AR) break;
            e += first ? RD : RP;
            first = 1'b0;
        end
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int gap);
        int n;
        @(negedge clk);
        n = cyc + 1;
        btn_up = up;
        btn_dn = dn;
        if (up ^ dn) push_steps(dn, n, hold);
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s missing_steps got %0d outstanding, expected 0 (next edge %0d)",
                     name, sbq.size(), sbq[0].edge_no);
        end
        sbq.delete();
    endtask

    task automatic check_counts(input string name, input int eu, input int ed);
        checks++;
        if (n_up != eu || n_dn != ed) begin
            failures++;
            $display("FAIL %s step_count got up=%0d down=%0d, expected up=%0d down=%0d",
                     name, n_up, n_dn, eu, ed);
        end
    endtask

    typedef struct {
        bit up;
        bit dn;
        int hold;
        int steps_ar;
        int steps_noar;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, m, steps;

        vecs[0] = '{1'b1, 1'b0, 15, 1, 1};   // clean up press
        vecs[1] = '{1'b0, 1'b1, 15, 1, 1};   // clean down press
        vecs[2] = '{1'b1, 1'b0, 3,  0, 0};   // shorter than debounce
        vecs[3] = '{1'b1, 1'b0, 4,  1, 1};   // exactly debounce length
        vecs[4] = '{1'b1, 1'b0, 60, 9, 1};   // long hold, repeats
        vecs[5] = '{1'b0, 1'b1, 40, 5, 1};   // down hold, repeats
        vecs[6] = '{1'b1, 1'b1, 30, 0, 0};   // both together -> lock

        // reset state
        #1;
        checks++;
        if (o_ena !== 1'b0 || o_up !== 1'b0 || o_down !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ena=%b up=%b down=%b, expected 000", o_ena, o_up, o_down);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            n_up = 0;
            n_dn = 0;
            press(vecs[i].up, vecs[i].dn, vecs[i].hold, 20);
            check_empty($sformatf("vec%0d", i));
            steps = AR ? vecs[i].steps_ar : vecs[i].steps_noar;
            check_counts($sformatf("vec%0d", i),
                         (vecs[i].up && !vecs[i].dn) ? steps : 0,
                         (vecs[i].dn && !vecs[i].up) ? steps : 0);
        end

        // bounce: down toggles every 2 cycles, never stable long enough
        n_up = 0;
        n_dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            btn_dn = ~btn_dn;
            @(negedge clk);
        end
        btn_dn = 1'b0;
        repeat (20) @(negedge clk);
        check_empty("bounce");
        check_counts("bounce", 0, 0);

        // lock: up held, down joins, partial release, full release, then down
        n_up = 0;
        n_dn = 0;
        @(negedge clk);
        n = cyc + 1;
        btn_up = 1'b1;
        push_steps(1'b0, n, 1000);
        sbq = sbq[0:0];              // only the initial step precedes the lock
        repeat (10) @(negedge clk);
        btn_dn = 1'b1;
        repeat (30) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        check_empty("lock_partial");
        check_counts("lock_partial", 1, 0);
        btn_dn = 1'b0;
        repeat (20) @(negedge clk);
        check_counts("lock_release", 1, 0);
        press(1'b0, 1'b1, 8, 20);
        check_empty("lock_after");
        check_counts("lock_after", 1, 1);

        // reset during a hold, button still held after release of reset
        n_up = 0;
        n_dn = 0;
        @(negedge clk);
        n = cyc + 1;
        btn_up = 1'b1;
        push_steps(1'b0, n, 1000);
        repeat (n + 35 - cyc) @(negedge clk);
        @(posedge clk);
        #1;
        if (AR) begin
            checks++;
            if (o_up !== 1'b1) begin
                failures++;
                $display("FAIL pre_reset_repeat got up=%b, expected 1", o_up);
            end
        end
        rst_n = 1'b0;
        sbq.delete();
        #1;
        checks++;
        if (o_ena !== 1'b0 || o_up !== 1'b0 || o_down !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got ena=%b up=%b down=%b, expected 000", o_ena, o_up, o_down);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_up = 0;
        n_dn = 0;
        m = cyc + 1;
        push_steps(1'b0, m, 40);
        repeat (40) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        check_empty("reset_rehold");
        check_counts("reset_rehold", AR ? 5 : 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
